// File: rtl/uart_pkg.sv
// Shared definitions for the buffered UART transmit stage: drain state
// encoding and default data/depth sizing.
package uart_pkg;

    localparam int DEFAULT_WIDTH      = 8;
    localparam int DEFAULT_DEPTH_LOG2 = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } drain_state_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Register-array storage for the transmit FIFO: one synchronous write port,
// one asynchronous read port.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int WIDTH      = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [DEPTH_LOG2-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic [DEPTH_LOG2-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [2**DEPTH_LOG2];

    // NOTE: storage carries no reset; the count makes stale entries
    // unreachable, and leaving it out keeps the array a plain register file.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Circular transmit FIFO plus drain state machine that hands one byte at a
// time to the UART transmitter over the Tx_Data/Tx_Send/Tx_Busy handshake.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int WIDTH      = DEFAULT_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [WIDTH-1:0]      Wr_Data,
    input  logic                  Wr_En,
    input  logic                  Flush,
    input  logic                  Clr_Ovf,
    output logic                  Full,
    output logic                  Empty,
    output logic [DEPTH_LOG2:0]   Count,
    output logic                  Overflow,
    output logic [WIDTH-1:0]      Tx_Data,
    output logic                  Tx_Send,
    input  logic                  Tx_Busy
);

    localparam logic [DEPTH_LOG2:0] DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [WIDTH-1:0]      rd_data;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  pop;
    logic                  push;
    logic                  ovf_set;
    drain_state_t          state;

    uart_fifo_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (WIDTH)
    ) u_mem (
        .clk     (Clk),
        .we      (push),
        .wr_addr (wr_ptr),
        .wr_data (Wr_Data),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        pop        = (state == IDLE) && !Empty && !Tx_Busy;
        push       = Wr_En && !Full && !Flush;
        ovf_set    = Wr_En && Full && !Flush;
        count_next = Count;
        if (Flush) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = Count + 1'b1;
        end else if (pop && !push) begin
            count_next = Count - 1'b1;
        end
    end

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            Count    <= '0;
            Empty    <= 1'b1;
            Full     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            Count <= count_next;
            Empty <= (count_next == '0);
            Full  <= (count_next == DEPTH_CNT);
            if (Flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end
            // A dropped write outranks a same-cycle clear.
            if (ovf_set) begin
                Overflow <= 1'b1;
            end else if (Clr_Ovf) begin
                Overflow <= 1'b0;
            end
        end
    end

    // Flush never touches the drain side: a popped byte still goes out.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            Tx_Send <= 1'b0;
            Tx_Data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        Tx_Data <= rd_data;
                        Tx_Send <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (Tx_Busy) begin
                        Tx_Send <= 1'b0;
                        state   <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!Tx_Busy) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    Tx_Send <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a transmitter model consumes characters and checks
// them against a queue of bytes the FIFO is expected to deliver in order.
module tb_uart_tx_fifo;

    localparam int DL = 4;
    localparam int W  = 8;

    logic         Clk     = 1'b0;
    logic         Reset   = 1'b0;
    logic [W-1:0] Wr_Data = '0;
    logic         Wr_En   = 1'b0;
    logic         Flush   = 1'b0;
    logic         Clr_Ovf = 1'b0;
    logic         Tx_Busy = 1'b0;
    logic         Full, Empty, Overflow, Tx_Send;
    logic [DL:0]  Count;
    logic [W-1:0] Tx_Data;

    int checks   = 0;
    int failures = 0;

    typedef enum int {BM_LOW, BM_HIGH, BM_MODEL} busy_mode_t;
    busy_mode_t   busy_mode = BM_LOW;
    int           busy_cnt  = 0;
    int           rx_count  = 0;
    int           send_viol = 0;
    logic         prev_send = 1'b0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] head;

    uart_tx_fifo #(.DEPTH_LOG2(DL), .WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Wr_Data  (Wr_Data),
        .Wr_En    (Wr_En),
        .Flush    (Flush),
        .Clr_Ovf  (Clr_Ovf),
        .Full     (Full),
        .Empty    (Empty),
        .Count    (Count),
        .Overflow (Overflow),
        .Tx_Data  (Tx_Data),
        .Tx_Send  (Tx_Send),
        .Tx_Busy  (Tx_Busy)
    );

    always #5 Clk = ~Clk;

    // Transmitter model: busy for 10 cycles per character, scoreboarded against exp_q.
    always @(negedge Clk) begin
        if (Tx_Send && !prev_send && Tx_Busy) send_viol++;
        prev_send = Tx_Send;
        case (busy_mode)
            BM_HIGH: begin Tx_Busy = 1'b1; busy_cnt = 0; end
            BM_LOW:  begin Tx_Busy = 1'b0; busy_cnt = 0; end
            default: begin
                if (busy_cnt != 0) begin
                    busy_cnt--;
                    if (busy_cnt == 0) Tx_Busy = 1'b0;
                end else if (Tx_Busy) begin
                    Tx_Busy = 1'b0;
                end else if (Tx_Send) begin
                    rx_count++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL tx_unexpected: sent %h, required no character", Tx_Data);
                    end else begin
                        head = exp_q.pop_front();
                        if (Tx_Data !== head) begin
                            failures++;
                            $display("FAIL tx_order: sent %h, required %h", Tx_Data, head);
                        end
                    end
                    Tx_Busy  = 1'b1;
                    busy_cnt = 10;
                end
            end
        endcase
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic put(input logic [W-1:0] d, input bit expect_sent);
        Wr_Data = d;
        Wr_En   = 1'b1;
        if (expect_sent) exp_q.push_back(d);
        tick();
        Wr_En = 1'b0;
    endtask

    task automatic wait_rx(input int target, input int budget, input string what);
        int n = 0;
        while (rx_count < target && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (rx_count < target) begin
            failures++;
            $display("FAIL %s_timeout: sent %0d characters, required %0d", what, rx_count, target);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        busy_mode = BM_LOW;
        repeat (2) tick();
        checks++; if (Count !== 5'd0)  begin failures++; $display("FAIL reset_count: got %0d, expected 0", Count); end
        checks++; if (Empty !== 1'b1)  begin failures++; $display("FAIL reset_empty: got %b, expected 1", Empty); end
        checks++; if (Full !== 1'b0)   begin failures++; $display("FAIL reset_full: got %b, expected 0", Full); end
        checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b, expected 0", Overflow); end
        checks++; if (Tx_Send !== 1'b0) begin failures++; $display("FAIL reset_send: got %b, expected 0", Tx_Send); end
        checks++; if (Tx_Data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h, expected 00", Tx_Data); end
        Reset = 1'b1;
        tick();
        // Transmitter never answers, so the drain sticks in SEND with two bytes queued.
        put(8'h5A, 1'b0);
        put(8'h5B, 1'b0);
        put(8'h5C, 1'b0);
        tick();
        checks++; if (Tx_Send !== 1'b1) begin failures++; $display("FAIL midsend_send: got %b, expected 1", Tx_Send); end
        #2 Reset = 1'b0;
        #1;
        checks++; if (Tx_Send !== 1'b0) begin failures++; $display("FAIL async_reset_send: got %b, expected 0", Tx_Send); end
        checks++; if (Count !== 5'd0)  begin failures++; $display("FAIL async_reset_count: got %0d, expected 0", Count); end
        checks++; if (Empty !== 1'b1)  begin failures++; $display("FAIL async_reset_empty: got %b, expected 1", Empty); end
        checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL async_reset_ovf: got %b, expected 0", Overflow); end
        tick();
        Reset = 1'b1;
        tick();
        exp_q.delete();
    endtask

    task automatic test_single();
        int rx0;
        busy_mode = BM_MODEL;
        tick();
        rx0 = rx_count;
        put(8'h41, 1'b1);
        checks++; if (Empty !== 1'b0)  begin failures++; $display("FAIL single_empty_n: got %b, expected 0", Empty); end
        checks++; if (Count !== 5'd1)  begin failures++; $display("FAIL single_count_n: got %0d, expected 1", Count); end
        checks++; if (Tx_Send !== 1'b0) begin failures++; $display("FAIL single_send_n: got %b, expected 0", Tx_Send); end
        tick();
        checks++; if (Tx_Send !== 1'b1) begin failures++; $display("FAIL single_send_n1: got %b, expected 1", Tx_Send); end
        checks++; if (Tx_Data !== 8'h41) begin failures++; $display("FAIL single_data: got %h, expected 41", Tx_Data); end
        checks++; if (Count !== 5'd0)  begin failures++; $display("FAIL single_count_n1: got %0d, expected 0", Count); end
        tick();
        checks++; if (Tx_Send !== 1'b0) begin failures++; $display("FAIL single_send_drop: got %b, expected 0", Tx_Send); end
        wait_rx(rx0 + 1, 20, "single");
        repeat (20) tick();
        checks++; if (rx_count !== rx0 + 1) begin failures++; $display("FAIL single_chars: got %0d, expected %0d", rx_count, rx0 + 1); end
        checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL single_empty_end: got %b, expected 1", Empty); end
    endtask

    task automatic test_burst_overflow();
        busy_mode = BM_HIGH;
        repeat (2) tick();
        for (int i = 0; i < 16; i++) put(8'(i), 1'b1);
        checks++; if (Full !== 1'b1)   begin failures++; $display("FAIL burst_full: got %b, expected 1", Full); end
        checks++; if (Count !== 5'd16) begin failures++; $display("FAIL burst_count: got %0d, expected 16", Count); end
        checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL burst_ovf: got %b, expected 0", Overflow); end
        put(8'hAA, 1'b0);
        checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL ovf_set: got %b, expected 1", Overflow); end
        checks++; if (Count !== 5'd16) begin failures++; $display("FAIL ovf_count: got %0d, expected 16", Count); end
        Clr_Ovf = 1'b1; tick(); Clr_Ovf = 1'b0;
        checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear: got %b, expected 0", Overflow); end
        Clr_Ovf = 1'b1;
        put(8'hBB, 1'b0);
        Clr_Ovf = 1'b0;
        checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL ovf_set_wins: got %b, expected 1", Overflow); end
        Clr_Ovf = 1'b1; tick(); Clr_Ovf = 1'b0;
    endtask

    task automatic test_drain_wrap();
        int rx0;
        rx0 = rx_count;
        busy_mode = BM_MODEL;
        wait_rx(rx0 + 10, 400, "drain_first");
        for (int i = 16; i < 24; i++) put(8'(i), 1'b1);
        wait_rx(rx0 + 24, 600, "drain_wrap");
        repeat (14) tick();
        checks++; if (rx_count !== rx0 + 24) begin failures++; $display("FAIL drain_chars: got %0d, expected %0d", rx_count, rx0 + 24); end
        checks++; if (Count !== 5'd0) begin failures++; $display("FAIL drain_count: got %0d, expected 0", Count); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL drain_pending: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int rx0;
        busy_mode = BM_HIGH;
        repeat (2) tick();
        for (int i = 0; i < 5; i++) put(8'($urandom), 1'b1);
        checks++; if (Count !== 5'd5) begin failures++; $display("FAIL sim_pre_count: got %0d, expected 5", Count); end
        rx0 = rx_count;
        busy_mode = BM_LOW;
        put(8'($urandom), 1'b1);
        checks++; if (Count !== 5'd5) begin failures++; $display("FAIL sim_count: got %0d, expected 5", Count); end
        checks++; if (Tx_Send !== 1'b1) begin failures++; $display("FAIL sim_send: got %b, expected 1", Tx_Send); end
        busy_mode = BM_MODEL;
        wait_rx(rx0 + 6, 200, "sim_drain");
        repeat (14) tick();
        busy_mode = BM_HIGH;
        repeat (2) tick();
        for (int i = 0; i < 16; i++) put(8'($urandom), 1'b1);
        checks++; if (Full !== 1'b1) begin failures++; $display("FAIL full_pre: got %b, expected 1", Full); end
        rx0 = rx_count;
        busy_mode = BM_LOW;
        put(8'($urandom), 1'b0);
        checks++; if (Count !== 5'd15) begin failures++; $display("FAIL full_pop_count: got %0d, expected 15", Count); end
        checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL full_pop_ovf: got %b, expected 1", Overflow); end
        checks++; if (Full !== 1'b0) begin failures++; $display("FAIL full_pop_full: got %b, expected 0", Full); end
        busy_mode = BM_MODEL;
        wait_rx(rx0 + 16, 400, "full_drain");
        repeat (14) tick();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL full_pending: got %0d, expected 0", exp_q.size()); end
    endtask

    task automatic test_flush();
        int rx0;
        logic [W-1:0] a;
        busy_mode = BM_HIGH;
        repeat (2) tick();
        for (int i = 0; i < 8; i++) put(8'($urandom), 1'b1);
        rx0 = rx_count;
        busy_mode = BM_MODEL;
        wait_rx(rx0 + 1, 20, "flush_first");
        repeat (2) tick();
        checks++; if (Count !== 5'd7) begin failures++; $display("FAIL flush_pre_count: got %0d, expected 7", Count); end
        Flush = 1'b1;
        put(8'hEE, 1'b0);
        Flush = 1'b0;
        exp_q.delete();
        checks++; if (Count !== 5'd0) begin failures++; $display("FAIL flush_count: got %0d, expected 0", Count); end
        checks++; if (Empty !== 1'b1) begin failures++; $display("FAIL flush_empty: got %b, expected 1", Empty); end
        checks++; if (Overflow !== 1'b1) begin failures++; $display("FAIL flush_ovf_kept: got %b, expected 1", Overflow); end
        repeat (40) tick();
        checks++; if (rx_count !== rx0 + 1) begin failures++; $display("FAIL flush_chars: got %0d, expected %0d", rx_count, rx0 + 1); end
        checks++; if (Tx_Send !== 1'b0) begin failures++; $display("FAIL flush_send: got %b, expected 0", Tx_Send); end
        // Flush landing on the same edge as an IDLE pop: popped byte still goes out.
        busy_mode = BM_HIGH;
        repeat (2) tick();
        a = 8'($urandom);
        put(a, 1'b1);
        put(8'($urandom), 1'b0);
        put(8'($urandom), 1'b0);
        busy_mode = BM_LOW;
        Flush = 1'b1; tick(); Flush = 1'b0;
        checks++; if (Tx_Send !== 1'b1) begin failures++; $display("FAIL flushpop_send: got %b, expected 1", Tx_Send); end
        checks++; if (Tx_Data !== a) begin failures++; $display("FAIL flushpop_data: got %h, expected %h", Tx_Data, a); end
        checks++; if (Count !== 5'd0) begin failures++; $display("FAIL flushpop_count: got %0d, expected 0", Count); end
        rx0 = rx_count;
        busy_mode = BM_MODEL;
        wait_rx(rx0 + 1, 20, "flushpop");
        repeat (30) tick();
        checks++; if (rx_count !== rx0 + 1) begin failures++; $display("FAIL flushpop_chars: got %0d, expected %0d", rx_count, rx0 + 1); end
        Clr_Ovf = 1'b1; tick(); Clr_Ovf = 1'b0;
        checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL flush_ovf_clear: got %b, expected 0", Overflow); end
    endtask

    task automatic test_random();
        int rx0;
        int wr = 0;
        int budget = 3000;
        rx0 = rx_count;
        busy_mode = BM_MODEL;
        while (wr < 40 && budget > 0) begin
            budget--;
            // Keep occupancy below depth so every byte must come out in order.
            if ($urandom_range(0, 3) == 0 && (wr - (rx_count - rx0)) < 14) begin
                Wr_Data = 8'($urandom);
                Wr_En   = 1'b1;
                exp_q.push_back(Wr_Data);
                wr++;
            end else begin
                Wr_En = 1'b0;
            end
            tick();
        end
        Wr_En = 1'b0;
        checks++; if (wr != 40) begin failures++; $display("FAIL rand_writes: got %0d, expected 40", wr); end
        wait_rx(rx0 + wr, 800, "rand");
        repeat (14) tick();
        checks++; if (Overflow !== 1'b0) begin failures++; $display("FAIL rand_ovf: got %b, expected 0", Overflow); end
        checks++; if (Count !== 5'd0) begin failures++; $display("FAIL rand_count: got %0d, expected 0", Count); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rand_pending: got %0d, expected 0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_burst_overflow();
        test_drain_wrap();
        test_back_to_back();
        test_flush();
        test_random();
        checks++;
        if (send_viol != 0) begin
            failures++;
            $display("FAIL send_while_busy: got %0d, expected 0", send_viol);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered transmit stage that sits directly upstream of the UART transmitter and drives its Tx_Data/Tx_Send/Tx_Busy handshake. Host logic writes bytes in bursts into a circular FIFO. A drain state machine hands bytes one at a time to the transmitter, so producers never stall on the serial bit rate. It also provides occupancy status and a sticky overflow flag.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (depth = 2^DEPTH_LOG2 entries, 16 by default)
WIDTH, 8, data width; must match the transmitter byte width

Ports:
Clk  input  1  system clock; all state changes on its rising edge
Reset  input  1  asynchronous, active-low reset
Wr_Data  input  WIDTH  byte to enqueue
Wr_En  input  1  enqueue strobe; one byte per cycle while high
Flush  input  1  synchronous FIFO clear
Clr_Ovf  input  1  clears Overflow
Full  output  1  FIFO holds 2^DEPTH_LOG2 entries
Empty  output  1  FIFO holds 0 entries
Count  output  DEPTH_LOG2+1  current occupancy, 0..2^DEPTH_LOG2
Overflow  output  1  sticky: a write was dropped
Tx_Data  output  WIDTH  byte presented to the transmitter
Tx_Send  output  1  send request to the transmitter
Tx_Busy  input  1  transmitter busy, high while a character is on the line

Behaviour:
- Reset low, asynchronously forces the following; all outputs are registered:
  - rd/wr pointers = 0, Count = 0, Empty = 1, Full = 0, Overflow = 0
  - Tx_Send = 0, Tx_Data = 0, state = IDLE
- A reset asserted mid-character drops Tx_Send immediately. The in-flight byte is abandoned and queued bytes are lost.
- Pointers are DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2. Count is maintained explicitly:
  - +1 on write only
  - −1 on pop only
  - unchanged on simultaneous write and pop
- Full = (Count == 2^DEPTH_LOG2). Empty = (Count == 0). Both are registered and consistent with Count in the same cycle.
- Write rules:
  - Wr_En with Full=0 stores Wr_Data at wr_ptr and increments wr_ptr.
  - Wr_En with Full=1 drops the byte and sets Overflow, even if a pop happens the same cycle.
  - Overflow stays set until Clr_Ovf. If set and clear happen in the same cycle, set wins.
- Drain FSM states:
  - IDLE: if Empty=0 and Tx_Busy=0, pop the head: Tx_Data <= mem[rd_ptr], rd_ptr+1, Count−1, Tx_Send <= 1, go to SEND.
  - SEND: hold Tx_Send=1 and Tx_Data stable until Tx_Busy=1 is sampled. Then Tx_Send <= 0 and go to WAIT_DONE.
  - WAIT_DONE: Tx_Send=0, Tx_Data held. When Tx_Busy=0 is sampled, go to IDLE.
- Latency:
  - A write at edge n into an empty FIFO with an idle transmitter gives Empty=0 after n and Tx_Send=1 after n+1.
  - Back-to-back characters need at least one IDLE cycle between the Tx_Busy fall and the next Tx_Send.
- Tx_Send is never asserted while Tx_Busy is high in IDLE. Exactly one pop occurs per character.
- Flush behaviour:
  - Flush resets the pointers and Count to 0 on the next edge. It does not clear Overflow.
  - It does not abort a byte already in SEND or WAIT_DONE.
  - Flush plus Wr_En in the same cycle: Flush wins and the write is discarded without setting Overflow.
  - Flush plus an IDLE pop in the same cycle: the pop completes (byte is sent) and the FIFO ends empty.
- Storage is write-first-independent: a same-cycle write and pop to the same slot cannot occur, because a pop needs Count ≥ 1 and a write needs Count < depth.

Decomposition:
- Shared package uart_pkg holds:
  - drain state encoding constants (IDLE=2'd0, SEND=2'd1, WAIT_DONE=2'd2)
  - default WIDTH (8) and DEPTH_LOG2 (4)
- One sub-module, uart_fifo_mem: 2^DEPTH_LOG2 × WIDTH register array with one synchronous write port and one asynchronous read port.
- Pointer, count and FSM logic stay in uart_tx_fifo.

Test Plan:
- Reset mid-SEND (Tx_Busy held low) -> Tx_Send falls without waiting for a clock edge; Count=0, Empty=1, Overflow=0.
- Write 0x41 to an empty FIFO, transmitter model raises Tx_Busy 1 cycle after Tx_Send for 10 cycles -> Tx_Send high exactly from edge n+1 until Busy is sampled, Tx_Data=0x41, Count returns to 0, a single character is sent.
- Burst-write 0x00..0x0F (16 bytes) while Tx_Busy is forced high -> Full=1, Count=16. A 17th write of 0xAA sets Overflow and is never transmitted; Clr_Ovf clears the flag.
- Release Tx_Busy with a model of 10-cycle characters -> bytes 0x00..0x0F emerge in order; the pointer wrap is exercised by a second burst of 0x10..0x17 after 10 pops.
- Simultaneous Wr_En and pop at Count=5 -> Count stays 5. With Full=1, Wr_En and an IDLE pop in the same cycle -> the write is dropped, Overflow=1, Count=15.
- Flush during WAIT_DONE with Count=7 plus a same-cycle Wr_En -> Count=0 and Overflow unchanged; the in-flight byte completes and no further Tx_Send follows.
